alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
- Sequential, handshaked successor to the combinational 8-bit ALU.
- Generalised in data width and opcode width, and adds a full 4-bit status word.
- Registers operands on acceptance and holds the result until the consumer takes it. Supports a multi-cycle shift-add multiply.
- Sits between the instruction sequencer (ROM fetch/decode) and the register file write-back.

Parameters:
- W, 8, data width in bits; any value ≥ 4. The shift amount width is $clog2(W).
- OP_W, 3, opcode width; must be ≥ 3. Opcodes above 7 are illegal.

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand/op presented.
- in_ready  out  1  block can accept; a transfer occurs when in_valid && in_ready.
- op  in  OP_W  operation code.
- a  in  W  operand A.
- b  in  W  operand B.
- out_valid  out  1  result/status valid.
- out_ready  in  1  consumer takes the result; a transfer occurs when out_valid && out_ready.
- result  out  W  operation result.
- status  out  4  flags: [0] zero, [1] carry, [2] negative, [3] overflow.
- busy  out  1  high while in the EXEC state (multiply in progress).

Behaviour:
- Reset (async assert, sync release):
  - State goes to IDLE.
  - out_valid = 0, result = 0, status = 0, busy = 0, in_ready = 1.
  - Internal multiply counter and accumulator are cleared.
- States:
  - IDLE: in_ready = 1. On acceptance of a single-cycle op, compute and go to DONE. On acceptance of MUL, go to EXEC.
  - EXEC: W iterations, one per cycle, then DONE. in_ready = 0, busy = 1.
  - DONE: out_valid = 1; result and status are held stable while out_ready = 0.
    - On out_ready, with no new acceptance: go to IDLE.
    - in_ready = out_ready in DONE. A simultaneous output transfer and input acceptance loads the new op that cycle. This gives one-per-cycle throughput for single-cycle ops.
- Latency:
  - Single-cycle ops: out_valid rises on the edge after acceptance (1 cycle).
  - MUL: out_valid rises W+1 cycles after acceptance.
- Opcodes (arithmetic modulo 2^W):
  - 0 ADD: result = a+b; carry = carry out of bit W-1; overflow = signed overflow.
  - 1 SUB: result = a-b; carry = borrow (1 when a < b unsigned); overflow = (a[W-1] != b[W-1]) && (result[W-1] != a[W-1]).
  - 2 AND, 3 OR, 4 XOR: carry = 0, overflow = 0.
  - 5 SHL, 6 SHR (logical) by b[$clog2(W)-1:0]:
    - carry = last bit shifted out; shift 0 gives carry = 0.
    - overflow = 0.
  - 7 MUL: see Optional Feature.
- zero = (result == 0). negative = result[W-1]. Both are computed for every op, including illegal ones.
- Illegal opcode (≥ 8, or 7 without the feature): completes in 1 cycle with result = 0, status = 4'b1001 (zero, overflow).
- Operands are captured at acceptance; changes on a/b/op afterwards have no effect.
- Asserting reset_n low in any state aborts the operation immediately; the pending result is discarded and the block does not emit out_valid.

Optional Feature:
- Macro: ALU_SEQ_MUL_EN.
- Defined: opcode 7 = unsigned multiply via shift-add over W cycles in EXEC, using a 2W-bit product.
  - result = product[W-1:0].
  - carry = overflow = (product[2W-1:W] != 0).
- Undefined: no EXEC state or multiply datapath is built and busy is tied to 0. Opcode 7 is illegal (1 cycle, result 0, status 4'b1001).

Test Plan:
- Reset, then ADD a=0x02 b=0x06, out_ready=1 -> next cycle result=0x08, status=4'b0000, out_valid for 1 cycle.
- ADD 0xFF+0x01 -> result=0x00, status=4'b0011. SUB 0x80-0x01 -> result=0x7F, status=4'b1000. SUB 0x01-0x02 -> result=0xFF, status=4'b0110.
- Backpressure: XOR 0xA5^0x5A with out_ready=0 for 5 cycles -> result=0xFF held, status=4'b0100, in_ready=0. Release out_ready with in_valid=1 (AND 0xF0&0x3C) -> same-cycle accept, next result=0x30.
- SHL 0x81 by 1 -> result=0x02, carry=1. SHR 0x01 by 0 -> result=0x01, carry=0. Opcode 7 without the macro -> result=0x00, status=4'b1001.
- With ALU_SEQ_MUL_EN: MUL 0x0D*0x0B -> busy for 8 cycles, out_valid at cycle 9, result=0x8F, status=4'b0100. MUL 0x10*0x10 -> result=0x00, status=4'b1011.
- Assert reset_n low mid-multiply (cycle 4) -> out_valid stays 0, busy=0, in_ready=1 asynchronously. A subsequent ADD 0x02+0x06 returns 0x08.

Source files
------------

// File: rtl/alu_seq.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : alu_seq                                                        |
// | Purpose : Sequential, handshaked ALU. Operands and opcode are captured   |
// |           on input acceptance; result and a 4-bit status word are held   |
// |           until the consumer takes them. An optional multi-cycle         |
// |           shift-add unsigned multiply is enabled by ALU_SEQ_MUL_EN.      |
// | Ports   : clock      - rising-edge system clock                          |
// |           reset_n    - asynchronous active-low reset                     |
// |           in_valid   - op/operands presented                             |
// |           in_ready   - block can accept this cycle                       |
// |           op         - operation code (OP_W bits, values above 7 illegal)|
// |           a, b       - operands (W bits)                                 |
// |           out_valid  - result/status valid                               |
// |           out_ready  - consumer takes the result                         |
// |           result     - operation result (W bits)                         |
// |           status     - {overflow, negative, carry, zero}                 |
// |           busy       - multiply in progress                              |
// | Macro   : ALU_SEQ_MUL_EN enables opcode 7 (unsigned multiply)            |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module alu_seq #(
   parameter int W    = 8,
   parameter int OP_W = 3
) (
   input  logic            clock,
   input  logic            reset_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [OP_W-1:0] op,
   input  logic [W-1:0]    a,
   input  logic [W-1:0]    b,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [W-1:0]    result,
   output logic [3:0]      status,
   output logic            busy
);

   localparam int c_SHW = $clog2(W);

   localparam logic [2:0] c_OP_ADD = 3'd0;
   localparam logic [2:0] c_OP_SUB = 3'd1;
   localparam logic [2:0] c_OP_AND = 3'd2;
   localparam logic [2:0] c_OP_OR  = 3'd3;
   localparam logic [2:0] c_OP_XOR = 3'd4;
   localparam logic [2:0] c_OP_SHL = 3'd5;
   localparam logic [2:0] c_OP_SHR = 3'd6;
   localparam logic [2:0] c_OP_MUL = 3'd7;

`ifdef ALU_SEQ_MUL_EN
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_DONE = 2'd2
   } state_t;
`else
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_DONE = 2'd2
   } state_t;
`endif

   state_t         state_q, state_d;
   logic [W-1:0]   result_q, result_d;
   logic [3:0]     status_q, status_d;

   // ------------------------------------------------------------------
   // Single-cycle datapath, evaluated on the live inputs so the result
   // can be registered in the same edge that accepts the operands.
   // ------------------------------------------------------------------
   logic [W:0]       w_sum;
   logic [W:0]       w_diff;
   logic [W:0]       w_shl;
   logic [W:0]       w_shr;
   logic [c_SHW-1:0] w_sh;
   logic [W-1:0]     w_res;
   logic             w_c;
   logic             w_v;
   logic [3:0]       w_st;
   logic             w_op_illegal;
   logic             w_accept;

   assign w_sh   = b[c_SHW-1:0];
   assign w_sum  = {1'b0, a} + {1'b0, b};
   assign w_diff = {1'b0, a} - {1'b0, b};
   // One guard bit on the far side of each shift catches the last bit
   // shifted out; a zero shift leaves the guard bit at 0.
   assign w_shl  = {1'b0, a} << w_sh;
   assign w_shr  = {a, 1'b0} >> w_sh;

   generate
      if (OP_W > 3) begin : g_op_wide
         assign w_op_illegal = |op[OP_W-1:3];
      end else begin : g_op_narrow
         assign w_op_illegal = 1'b0;
      end
   endgenerate

`ifdef ALU_SEQ_MUL_EN
   logic w_is_mul;
`endif

   always_comb begin
      w_res = '0;
      w_c   = 1'b0;
      w_v   = 1'b0;
`ifdef ALU_SEQ_MUL_EN
      w_is_mul = 1'b0;
`endif
      if (w_op_illegal) begin
         w_v = 1'b1;
      end else begin
         case (op[2:0])
            c_OP_ADD: begin
               w_res = w_sum[W-1:0];
               w_c   = w_sum[W];
               w_v   = (a[W-1] == b[W-1]) && (w_sum[W-1] != a[W-1]);
            end
            c_OP_SUB: begin
               w_res = w_diff[W-1:0];
               w_c   = w_diff[W];   // borrow
               w_v   = (a[W-1] != b[W-1]) && (w_diff[W-1] != a[W-1]);
            end
            c_OP_AND: w_res = a & b;
            c_OP_OR:  w_res = a | b;
            c_OP_XOR: w_res = a ^ b;
            c_OP_SHL: begin
               w_res = w_shl[W-1:0];
               w_c   = w_shl[W];
            end
            c_OP_SHR: begin
               w_res = w_shr[W:1];
               w_c   = w_shr[0];
            end
            c_OP_MUL: begin
`ifdef ALU_SEQ_MUL_EN
               w_is_mul = 1'b1;
`else
               w_v = 1'b1;
`endif
            end
         endcase
      end
      w_st = {w_v, w_res[W-1], w_c, (w_res == '0)};
   end

   // ------------------------------------------------------------------
   // Multiply datapath: shift-add, one multiplier bit per EXEC cycle.
   // ------------------------------------------------------------------
`ifdef ALU_SEQ_MUL_EN
   localparam logic [c_SHW-1:0] c_LAST = c_SHW'(W - 1);

   logic [2*W-1:0]   acc_q, acc_d;
   logic [2*W-1:0]   mcand_q, mcand_d;
   logic [W-1:0]     mplier_q, mplier_d;
   logic [c_SHW-1:0] cnt_q, cnt_d;
   logic [2*W-1:0]   w_prod;
   logic             w_prod_hi;

   assign w_prod    = acc_q + (mplier_q[0] ? mcand_q : '0);
   assign w_prod_hi = (w_prod[2*W-1:W] != '0);
`endif

   assign in_ready  = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
   assign out_valid = (state_q == S_DONE);
   assign w_accept  = in_valid && in_ready;
   assign result    = result_q;
   assign status    = status_q;
`ifdef ALU_SEQ_MUL_EN
   assign busy      = (state_q == S_EXEC);
`else
   assign busy      = 1'b0;
`endif

   always_comb begin
      state_d  = state_q;
      result_d = result_q;
      status_d = status_q;
`ifdef ALU_SEQ_MUL_EN
      acc_d    = acc_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      cnt_d    = cnt_q;
`endif
      case (state_q)
         S_IDLE, S_DONE: begin
            // In DONE, acceptance implies out_ready, so loading a new op
            // here also retires the held result in the same cycle.
            if (w_accept) begin
`ifdef ALU_SEQ_MUL_EN
               if (w_is_mul) begin
                  state_d  = S_EXEC;
                  acc_d    = '0;
                  mcand_d  = {{W{1'b0}}, a};
                  mplier_d = b;
                  cnt_d    = '0;
               end else
`endif
               begin
                  state_d  = S_DONE;
                  result_d = w_res;
                  status_d = w_st;
               end
            end else if ((state_q == S_DONE) && out_ready) begin
               state_d = S_IDLE;
            end
         end
`ifdef ALU_SEQ_MUL_EN
         S_EXEC: begin
            acc_d    = w_prod;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == c_LAST) begin
               state_d  = S_DONE;
               result_d = w_prod[W-1:0];
               status_d = {w_prod_hi, w_prod[W-1], w_prod_hi, (w_prod[W-1:0] == '0)};
            end
         end
`endif
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= S_IDLE;
         result_q <= '0;
         status_q <= '0;
`ifdef ALU_SEQ_MUL_EN
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         cnt_q    <= '0;
`endif
      end else begin
         state_q  <= state_d;
         result_q <= result_d;
         status_q <= status_d;
`ifdef ALU_SEQ_MUL_EN
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         cnt_q    <= cnt_d;
`endif
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_alu_seq                                                     |
// | Purpose : Self-checking bench for alu_seq (W=8, OP_W=4). Directed steps  |
// |           followed by a randomized handshake stream checked against an   |
// |           integer-arithmetic reference model. Honors ALU_SEQ_MUL_EN.     |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module tb_alu_seq;

   logic       clock = 1'b0;
   logic       reset_n;
   logic       in_valid;
   logic       in_ready;
   logic [3:0] op;
   logic [7:0] a;
   logic [7:0] b;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] result;
   logic [3:0] status;
   logic       busy;

   int checks   = 0;
   int failures = 0;

   alu_seq #(.W(8), .OP_W(4)) dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .status    (status),
      .busy      (busy)
   );

   always #5 clock = ~clock;

   initial begin
      #1000000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference model: returns {status, result} from plain integer arithmetic.
   function automatic logic [11:0] model(input logic [3:0] mop, input logic [7:0] ma,
                                         input logic [7:0] mb);
      int unsigned ua, ub, r, sh;
      int          sa, sb, sr;
      logic        c, v;
      logic [7:0]  res;
      ua = ma;
      ub = mb;
      sa = (ua >= 128) ? int'(ua) - 256 : int'(ua);
      sb = (ub >= 128) ? int'(ub) - 256 : int'(ub);
      sh = ub % 8;
      r  = 0;
      c  = 1'b0;
      v  = 1'b0;
      case (mop)
         4'd0: begin
            r  = ua + ub;
            c  = (r > 255);
            sr = sa + sb;
            v  = (sr > 127) || (sr < -128);
         end
         4'd1: begin
            r  = ua - ub;
            c  = (ua < ub);
            sr = sa - sb;
            v  = (sr > 127) || (sr < -128);
         end
         4'd2: r = ua & ub;
         4'd3: r = ua | ub;
         4'd4: r = ua ^ ub;
         4'd5: begin
            r = ua << sh;
            c = (sh != 0) && (((ua >> (8 - sh)) & 1) != 0);
         end
         4'd6: begin
            r = ua >> sh;
            c = (sh != 0) && (((ua >> (sh - 1)) & 1) != 0);
         end
`ifdef ALU_SEQ_MUL_EN
         4'd7: begin
            r = ua * ub;
            c = (r > 255);
            v = c;
         end
`endif
         default: v = 1'b1;
      endcase
      res = r[7:0];
      return {v, res[7], c, (res == 8'h00), res};
   endfunction

   // Present an op and hold it until accepted; returns one step after the
   // accepting edge.
   task automatic issue(input logic [3:0] iop, input logic [7:0] ia, input logic [7:0] ib);
      op       = iop;
      a        = ia;
      b        = ib;
      in_valid = 1'b1;
      #1;
      for (int k = 0; k < 40 && !in_ready; k++) begin
         @(posedge clock);
         #2;
      end
      chk1("accept_ready", in_ready, 1'b1);
      @(posedge clock);
      #1;
      in_valid = 1'b0;
      op       = 4'($urandom);
      a        = 8'($urandom);
      b        = 8'($urandom);
   endtask

   task automatic chk_out(input string tag, input logic [7:0] er, input logic [3:0] es);
      chk1({tag, "_valid"}, out_valid, 1'b1);
      chk8({tag, "_result"}, result, er);
      chk4({tag, "_status"}, status, es);
   endtask

   logic [11:0] q[$];
   logic [11:0] exp_v;
   logic        acc_now, out_now;
   logic [3:0]  rop;

   initial begin
      reset_n   = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      op        = '0;
      a         = '0;
      b         = '0;
      repeat (2) @(posedge clock);
      #1;
      chk1("rst_out_valid", out_valid, 1'b0);
      chk1("rst_in_ready", in_ready, 1'b1);
      chk1("rst_busy", busy, 1'b0);
      chk8("rst_result", result, 8'h00);
      chk4("rst_status", status, 4'b0000);
      reset_n = 1'b1;
      @(posedge clock);
      #1;

      // Basic arithmetic
      issue(4'd0, 8'h02, 8'h06);
      chk_out("add", 8'h08, 4'b0000);
      @(posedge clock);
      #1;
      chk1("add_pulse", out_valid, 1'b0);
      issue(4'd0, 8'hFF, 8'h01);
      chk_out("add_carry", 8'h00, 4'b0011);
      issue(4'd1, 8'h80, 8'h01);
      chk_out("sub_ovf", 8'h7F, 4'b1000);
      issue(4'd1, 8'h01, 8'h02);
      chk_out("sub_borrow", 8'hFF, 4'b0110);
      @(posedge clock);
      #1;

      // Backpressure: result held, inputs ignored, then same-cycle reload
      out_ready = 1'b0;
      issue(4'd4, 8'hA5, 8'h5A);
      chk_out("xor", 8'hFF, 4'b0100);
      for (int k = 0; k < 5; k++) begin
         a = 8'($urandom);
         b = 8'($urandom);
         @(posedge clock);
         #1;
         chk8("hold_result", result, 8'hFF);
         chk4("hold_status", status, 4'b0100);
         chk1("hold_valid", out_valid, 1'b1);
         chk1("hold_in_ready", in_ready, 1'b0);
      end
      op        = 4'd2;
      a         = 8'hF0;
      b         = 8'h3C;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      #1;
      chk1("release_in_ready", in_ready, 1'b1);
      @(posedge clock);
      #1;
      in_valid = 1'b0;
      chk_out("and_b2b", 8'h30, 4'b0000);

      // Shifts and illegal opcodes
      issue(4'd5, 8'h81, 8'h01);
      chk_out("shl1", 8'h02, 4'b0010);
      issue(4'd6, 8'h01, 8'h00);
      chk_out("shr0", 8'h01, 4'b0000);
      issue(4'd6, 8'h81, 8'h01);
      chk_out("shr1", 8'h40, 4'b0010);
`ifndef ALU_SEQ_MUL_EN
      issue(4'd7, 8'h0D, 8'h0B);
      chk_out("op7_illegal", 8'h00, 4'b1001);
`endif
      issue(4'd9, 8'h12, 8'h34);
      chk_out("op9_illegal", 8'h00, 4'b1001);
      @(posedge clock);
      #1;

`ifdef ALU_SEQ_MUL_EN
      issue(4'd7, 8'h0D, 8'h0B);
      for (int k = 0; k < 8; k++) begin
         chk1("mul_busy", busy, 1'b1);
         chk1("mul_not_valid", out_valid, 1'b0);
         chk1("mul_not_ready", in_ready, 1'b0);
         @(posedge clock);
         #1;
      end
      chk_out("mul", 8'h8F, 4'b0100);
      chk1("mul_busy_done", busy, 1'b0);
      issue(4'd7, 8'h10, 8'h10);
      repeat (8) @(posedge clock);
      #1;
      chk_out("mul_hi", 8'h00, 4'b1011);
      @(posedge clock);
      #1;
      // Abort a multiply in its 4th busy cycle
      issue(4'd7, 8'h0D, 8'h0B);
      repeat (3) @(posedge clock);
      #1;
      chk1("abort_busy_before", busy, 1'b1);
`else
      // Abort a held result
      out_ready = 1'b0;
      issue(4'd0, 8'h33, 8'h44);
      chk1("abort_valid_before", out_valid, 1'b1);
`endif
      #2;
      reset_n = 1'b0;
      #1;
      chk1("abort_out_valid", out_valid, 1'b0);
      chk1("abort_busy", busy, 1'b0);
      chk1("abort_in_ready", in_ready, 1'b1);
      chk8("abort_result", result, 8'h00);
      @(posedge clock);
      #1;
      reset_n   = 1'b1;
      out_ready = 1'b1;
      @(posedge clock);
      #1;
      chk1("post_abort_valid", out_valid, 1'b0);
      issue(4'd0, 8'h02, 8'h06);
      chk_out("post_abort_add", 8'h08, 4'b0000);
      @(posedge clock);
      #1;

      // Randomized handshake stream against the reference model
      q.delete();
      for (int i = 0; i < 200; i++) begin
         rop = 4'($urandom);
`ifdef ALU_SEQ_MUL_EN
         if (rop == 4'd7) rop = 4'd0;
`endif
         op        = rop;
         a         = 8'($urandom);
         b         = 8'($urandom);
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
         #1;
         chk1("rnd_in_ready", in_ready, (q.size() == 0) || out_ready);
         chk1("rnd_out_valid", out_valid, q.size() != 0);
         if (q.size() != 0) begin
            exp_v = q[0];
            chk8("rnd_result", result, exp_v[7:0]);
            chk4("rnd_status", status, exp_v[11:8]);
         end
         acc_now = in_valid && in_ready;
         out_now = out_valid && out_ready;
         exp_v   = model(op, a, b);
         @(posedge clock);
         #1;
         if (out_now && q.size() != 0) void'(q.pop_front());
         if (acc_now) q.push_back(exp_v);
      end
      in_valid = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
